// File: rtl/bcd_to_bin_seq_if.sv
// Digit-entry to binary converter handshake: six BCD digits and start in,
// registered binary result with busy/done/invalid status out.
interface bcd_to_bin_seq_if #(
  parameter int BIN_W = 20
);
  logic             start;
  logic [3:0]       bcd_digit_0;
  logic [3:0]       bcd_digit_1;
  logic [3:0]       bcd_digit_2;
  logic [3:0]       bcd_digit_3;
  logic [3:0]       bcd_digit_4;
  logic [3:0]       bcd_digit_5;
  logic [BIN_W-1:0] bin_number;
  logic             busy;
  logic             done;
  logic             invalid;

  modport master (
    output start, bcd_digit_0, bcd_digit_1, bcd_digit_2,
           bcd_digit_3, bcd_digit_4, bcd_digit_5,
    input  bin_number, busy, done, invalid
  );

  modport slave (
    input  start, bcd_digit_0, bcd_digit_1, bcd_digit_2,
           bcd_digit_3, bcd_digit_4, bcd_digit_5,
    output bin_number, busy, done, invalid
  );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble: one right
// shift of {bcd, bin} per cycle, then -3 on every BCD digit that reads >= 8.
module bcd_to_bin_seq #(
  parameter int NUM_DIGITS = 6,
  parameter int BIN_W      = 20,
  parameter int CNT_W      = 5
) (
  input  logic            clk,
  input  logic            reset,
  bcd_to_bin_seq_if.slave bus
);
  localparam int BCD_W = 4 * NUM_DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                   state;
  logic [BCD_W-1:0]         bcd_q;
  logic [BIN_W-1:0]         bin_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [BIN_W-1:0]         bin_number;
  logic                     busy;
  logic                     done;
  logic                     invalid;

  logic [BCD_W-1:0]         digits_in;
  logic                     any_bad;
  logic [BCD_W+BIN_W-1:0]   shifted;
  logic [BCD_W-1:0]         bcd_corr;
  logic [BIN_W-1:0]         bin_sh;

  // Most significant digit sits at the top of the packed BCD word.
  assign digits_in = {bus.bcd_digit_5, bus.bcd_digit_4, bus.bcd_digit_3,
                      bus.bcd_digit_2, bus.bcd_digit_1, bus.bcd_digit_0};

  assign shifted = {1'b0, bcd_q, bin_q[BIN_W-1:1]};
  assign bin_sh  = shifted[BIN_W-1:0];

  // NOTE: every always_comb output gets a default before any conditional
  // update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    bcd_corr = shifted[BCD_W+BIN_W-1:BIN_W];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_corr[4*i +: 4] >= 4'd8)
        bcd_corr[4*i +: 4] = bcd_corr[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digits_in[4*i +: 4] > 4'd9)
        any_bad = 1'b1;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      bin_number <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      invalid    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bcd_q <= digits_in;
            bin_q <= '0;
            cnt_q <= '0;
            if (any_bad) begin
              // Bad digit: report immediately without entering SHIFT.
              bin_number <= '0;
              invalid    <= 1'b1;
              done       <= 1'b1;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end

        SHIFT: begin
          bcd_q <= bcd_corr;
          bin_q <= bin_sh;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BIN_W - 1)) begin
            bin_number <= bin_sh;
            invalid    <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bin_number = bin_number;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.invalid    = invalid;
endmodule
